spi_slave_regfile: RTL and testbench
====================================

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 The block SHALL have parameter SPI_ADDR_WIDTH, default 6: frame address field width.
REQ-002 The block SHALL have parameter SPI_DATA_WIDTH, default 20: frame data field and register width.
REQ-003 The block SHALL have parameter REG_NUM, default 16: number of implemented registers at addresses 0..REG_NUM-1.
REQ-004 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-005 The block SHALL have port i_clk_sys, input, 1 bit: system clock.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port i_spi_sclk, input, 1 bit: SPI clock from the master, asynchronous.
REQ-008 The block SHALL have port i_spi_cs_n, input, 1 bit: chip select, active-low, asynchronous.
REQ-009 The block SHALL have port i_spi_mosi, input, 1 bit: master-to-slave data.
REQ-010 The block SHALL have port o_spi_miso, output, 1 bit: slave-to-master data.
REQ-011 The block SHALL have port o_wr_pulse, output, 1 bit: one-cycle register-write strobe.
REQ-012 The block SHALL have port o_wr_addr, output, SPI_ADDR_WIDTH bits: address of the last write.
REQ-013 The block SHALL have port o_wr_data, output, SPI_DATA_WIDTH bits: data of the last write.
REQ-014 The block SHALL have port o_frame_err, output, 1 bit: one-cycle strobe for an aborted frame.
REQ-015 The block SHALL have port o_err_cnt, output, 8 bits: saturating count of aborted frames.

Function
REQ-016 The block SHALL pass SCLK, CS_n and MOSI through 2-FF synchronizers and SHALL detect SCLK edges on the synchronized signals; a supported SCLK is at most i_clk_sys/8.
REQ-017 The SPI mode SHALL be mode 0: MOSI is sampled on the SCLK rising edge and MISO changes after the SCLK falling edge.
REQ-018 A frame SHALL be 27 bits, MSB first, ordered as rw (1 = write, 0 = read), then addr[5:0], then data[19:0].
REQ-019 The state machine SHALL have the states WAIT_CS, IDLE, CMD, DATA and DONE.
REQ-020 WAIT_CS SHALL go to IDLE when CS_n is high; IDLE SHALL go to CMD on the CS_n falling edge.
REQ-021 CMD SHALL go to DATA after 7 rising edges; DATA SHALL go to DONE after 20 further rising edges; DONE SHALL go to IDLE on CS_n high.
REQ-022 On a write frame, the 27th rising edge SHALL update reg[addr] when addr < REG_NUM.
REQ-023 On a write frame, o_wr_addr and o_wr_data SHALL be updated, and o_wr_pulse SHALL be high for exactly 1 cycle, within 2 clocks of the synchronized 27th rising edge.
REQ-024 A write to an address >= REG_NUM SHALL raise o_wr_pulse but SHALL NOT change any register.
REQ-025 On a read frame, the 7th rising edge SHALL load the shift register with reg[addr], or with 0 when addr >= REG_NUM (subject to REQ-037).
REQ-026 On a read frame, the data MSB SHALL appear on o_spi_miso before the next SCLK rising edge, and each following SCLK falling edge SHALL shift out the next bit.
REQ-027 o_spi_miso SHALL be 0 when CS_n is high, during CMD, on write frames and in DONE.
REQ-028 A CS_n rising edge in CMD or DATA SHALL abort the frame: no write, 1-cycle o_frame_err, o_err_cnt incremented, next state IDLE.
REQ-029 o_err_cnt SHALL saturate at 255.
REQ-030 Bits received in DONE beyond 27 SHALL be ignored, with no error and no second write.
REQ-031 A CS_n falling edge and an SCLK rising edge synchronized in the same cycle SHALL count the edge as frame bit 1.
REQ-032 A read and a write to the same register never occur in the same cycle; reads SHALL return the value committed before the frame's 7th rising edge.

Reset
REQ-033 While i_rst_n=0 at a rising edge of i_clk_sys, all registers SHALL be set to 0.
REQ-034 While i_rst_n=0, o_spi_miso, o_wr_pulse, o_wr_addr, o_wr_data, o_frame_err and o_err_cnt SHALL be 0 and the synchronizers SHALL be loaded with idle values (CS_n=1, SCLK=0).
REQ-035 After reset the state SHALL be WAIT_CS, so a frame already in progress at reset release is discarded without an error count.

Configuration
REQ-036 The macro SPI_SLAVE_ERR_CNT_EN SHALL select whether the error counter is compiled in.
REQ-037 With SPI_SLAVE_ERR_CNT_EN defined, the counter SHALL be implemented and a read of address 63 SHALL return {12'b0, o_err_cnt}; writes to 63 SHALL clear the counter.
REQ-038 Without SPI_SLAVE_ERR_CNT_EN, o_err_cnt SHALL be tied to 0, the counter logic SHALL be absent and address 63 SHALL behave as unimplemented; o_frame_err SHALL still pulse.

Verification
REQ-039 Write rw=1, addr=3, data=0xA5A5A, then read addr 3 -> 1 o_wr_pulse with o_wr_addr=3 and o_wr_data=0xA5A5A; MISO returns 0xA5A5A MSB first.
REQ-040 Read addr 20 after writing 0x12345 to addr 20 -> o_wr_pulse seen, MISO returns 0x00000.
REQ-041 CS_n raised after 15 bits of a write to addr 1 with data 0xFFFFF -> reg1 unchanged, o_frame_err pulses once, o_err_cnt=1.
REQ-042 Frame of 35 SCLKs writing 0x00001 to addr 2 -> exactly one o_wr_pulse, reg2=0x00001, no error.
REQ-043 i_rst_n pulsed low mid-frame with CS_n held low for the remaining bits -> no write, no error; the next full frame after CS_n goes high works.
REQ-044 With SPI_SLAVE_ERR_CNT_EN defined, 300 aborted frames then a read of addr 63 -> o_err_cnt=255, MISO returns 0x000FF; a write to 63 -> o_err_cnt=0.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a register file: 27-bit frames {rw, addr[5:0], data[19:0]}, MSB first.
// Define SPI_SLAVE_ERR_CNT_EN to build in the saturating aborted-frame counter, readable/clearable at the all-ones address.
module spi_slave_regfile #(
  parameter int unsigned SPI_ADDR_WIDTH = 6,
  parameter int unsigned SPI_DATA_WIDTH = 20,
  parameter int unsigned REG_NUM        = 16
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst_n,
  input  logic                      i_spi_sclk,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  output logic                      o_wr_pulse,
  output logic [SPI_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [SPI_DATA_WIDTH-1:0] o_wr_data,
  output logic                      o_frame_err,
  output logic [7:0]                o_err_cnt
);

  localparam int unsigned AW         = SPI_ADDR_WIDTH;
  localparam int unsigned DW         = SPI_DATA_WIDTH;
  localparam int unsigned CMD_BITS   = 1 + AW;
  localparam int unsigned FRAME_BITS = CMD_BITS + DW;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned IDX_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
`ifdef SPI_SLAVE_ERR_CNT_EN
  localparam logic [AW-1:0] ERR_ADDR = '1;
`endif

  typedef enum logic [2:0] {WAIT_CS, IDLE, CMD, DATA, DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        sclk_sync, cs_sync, mosi_sync;
  logic              sclk_prev, cs_prev;
  logic [1:0]        sync_ok;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DW-2:0]     rx_sr;
  logic [DW-1:0]     tx_sr;
  logic              rw_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     regs [REG_NUM];

  logic              sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  logic              shift_c, cmd_done_c, frame_done_c, abort_c, tx_shift_c, wr_en_c;
  logic [DW-1:0]     rx_next_c, rd_data_c;
  logic [AW-1:0]     cmd_addr_c;

  // Input synchronizers; sync_ok holds off WAIT_CS until the chain carries post-reset samples
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      sync_ok   <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], i_spi_sclk};
      cs_sync   <= {cs_sync[0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[0], i_spi_mosi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
      sync_ok   <= {sync_ok[0], 1'b1};
    end
  end

  assign sclk_rise_c = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall_c = ~sclk_sync[1] & sclk_prev;
  assign cs_rise_c   = cs_sync[1] & ~cs_prev;
  assign cs_fall_c   = ~cs_sync[1] & cs_prev;
  assign rx_next_c   = {rx_sr, mosi_sync[1]};
  assign cmd_addr_c  = rx_next_c[AW-1:0];
  assign wr_en_c     = frame_done_c & rw_q;

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) state <= WAIT_CS;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    shift_c      = 1'b0;
    cmd_done_c   = 1'b0;
    frame_done_c = 1'b0;
    abort_c      = 1'b0;
    tx_shift_c   = 1'b0;
    case (state)
      WAIT_CS: if (sync_ok[1] && cs_sync[1]) state_next = IDLE;
      IDLE: begin
        // an SCLK rise seen together with the CS_n fall is frame bit 1
        if (cs_fall_c) begin
          state_next = CMD;
          shift_c    = sclk_rise_c;
        end
      end
      CMD: begin
        if (cs_rise_c) begin
          abort_c    = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise_c) begin
          shift_c = 1'b1;
          if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
            cmd_done_c = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise_c) begin
          abort_c    = 1'b1;
          state_next = IDLE;
        end else begin
          // the fall right after the command keeps the freshly loaded MSB on the line
          tx_shift_c = sclk_fall_c && (bit_cnt != CNT_W'(CMD_BITS));
          if (sclk_rise_c) begin
            shift_c = 1'b1;
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              frame_done_c = 1'b1;
              state_next   = DONE;
            end
          end
        end
      end
      DONE: if (cs_sync[1]) state_next = IDLE;
      default: state_next = WAIT_CS;
    endcase
  end

  // Read mux over the address completed by the current (7th) rising edge
  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      if (cmd_addr_c == AW'(i)) rd_data_c = regs[IDX_W'(i)];
    end
`ifdef SPI_SLAVE_ERR_CNT_EN
    if (cmd_addr_c == ERR_ADDR) rd_data_c = DW'(o_err_cnt);
`endif
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      o_spi_miso  <= 1'b0;
      o_wr_pulse  <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_err <= 1'b0;
      for (int unsigned i = 0; i < REG_NUM; i++) regs[IDX_W'(i)] <= '0;
    end else begin
      if (state != CMD && state != DATA) bit_cnt <= CNT_W'(shift_c);
      else if (shift_c)                  bit_cnt <= bit_cnt + CNT_W'(1);
      if (shift_c) rx_sr <= rx_next_c[DW-2:0];
      if (cmd_done_c) begin
        rw_q   <= rx_next_c[CMD_BITS-1];
        addr_q <= cmd_addr_c;
        tx_sr  <= rx_next_c[CMD_BITS-1] ? '0 : rd_data_c;
      end else if (tx_shift_c) begin
        tx_sr <= {tx_sr[DW-2:0], 1'b0};
      end
      o_spi_miso  <= (state == DATA) && !rw_q && tx_sr[DW-1];
      o_wr_pulse  <= wr_en_c;
      o_frame_err <= abort_c;
      if (wr_en_c) begin
        o_wr_addr <= addr_q;
        o_wr_data <= rx_next_c;
      end
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        if (wr_en_c && addr_q == AW'(i)) regs[IDX_W'(i)] <= rx_next_c;
      end
    end
  end

`ifdef SPI_SLAVE_ERR_CNT_EN
  // Saturating aborted-frame counter, cleared by a write to the all-ones address
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n)                                o_err_cnt <= '0;
    else if (abort_c && o_err_cnt != 8'hFF)      o_err_cnt <= o_err_cnt + 8'd1;
    else if (wr_en_c && addr_q == ERR_ADDR)      o_err_cnt <= '0;
  end
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: bit-banged mode-0 master, register model and write/read scoreboards.
module tb_spi_slave_regfile;

  localparam int HALF = 8;
`ifdef SPI_SLAVE_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n, mosi;
  logic        miso, wr_pulse, frame_err;
  logic [5:0]  wr_addr;
  logic [19:0] wr_data;
  logic [7:0]  err_cnt;

  int          tests = 0;
  int          fails = 0;
  int          wr_pulses = 0;
  int          err_pulses = 0;
  bit          prev_wr = 1'b0;
  bit          prev_err = 1'b0;
  logic [25:0] wr_q [$];
  logic [19:0] rd_q [$];
  logic [25:0] exp_wr;
  logic [19:0] model [16];
  int          model_err;

  always #5 clk = ~clk;

  spi_slave_regfile dut (
    .i_clk_sys   (clk),
    .i_rst_n     (rst_n),
    .i_spi_sclk  (sclk),
    .i_spi_cs_n  (cs_n),
    .i_spi_mosi  (mosi),
    .o_spi_miso  (miso),
    .o_wr_pulse  (wr_pulse),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_frame_err (frame_err),
    .o_err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_err();
    return ERR_EN ? 8'(model_err) : 8'h00;
  endfunction

  // Write-strobe monitor: pops the expected {addr,data} for every pulse, checks 1-cycle width
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      wr_pulses++;
      tests++;
      assert (!prev_wr) else begin
        fails++;
        $error("FAIL wr_pulse_width: observed >1 cycle expected 1 cycle");
      end
      if (!prev_wr) begin
        tests++;
        assert (wr_q.size() != 0) else begin
          fails++;
          $error("FAIL wr_unexpected: observed pulse addr 0x%0h expected no pulse", wr_addr);
        end
        if (wr_q.size() != 0) begin
          exp_wr = wr_q.pop_front();
          tests++;
          assert ({wr_addr, wr_data} === exp_wr) else begin
            fails++;
            $error("FAIL wr_payload: observed 0x%0h/0x%0h expected 0x%0h/0x%0h",
                   wr_addr, wr_data, exp_wr[25:20], exp_wr[19:0]);
          end
        end
      end
    end
    if (frame_err === 1'b1) begin
      err_pulses++;
      tests++;
      assert (!prev_err) else begin
        fails++;
        $error("FAIL frame_err_width: observed >1 cycle expected 1 cycle");
      end
    end
    prev_wr  = (wr_pulse === 1'b1);
    prev_err = (frame_err === 1'b1);
  end

  // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rising edge
  task automatic spi_frame(input logic rw, input logic [5:0] addr, input logic [19:0] data,
                           input int nbits, input int rst_at, input bit sync_start,
                           output logic [19:0] rdata, output bit stray);
    logic [26:0] sr;
    sr    = {rw, addr, data};
    rdata = '0;
    stray = 1'b0;
    if (!sync_start) begin
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    for (int k = 1; k <= nbits; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      mosi = sr[26];
      sr   = {sr[25:0], 1'b0};
      if (k == 1 && sync_start) cs_n = 1'b0;
      else repeat (HALF) @(negedge clk);
      if (k >= 8 && k <= 27 && !rw) rdata = {rdata[18:0], miso};
      else if (miso !== 1'b0) stray = 1'b1;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [19:0] d, input int nbits,
                          input bit sync_start, input string tag);
    int w0, e0;
    logic [19:0] rd;
    bit stray;
    w0 = wr_pulses;
    e0 = err_pulses;
    wr_q.push_back({a, d});
    spi_frame(1'b1, a, d, nbits, 0, sync_start, rd, stray);
    if (a < 6'd16) model[a[3:0]] = d;
    if (ERR_EN && a == 6'd63) model_err = 0;
    check({tag, "_pulses"}, 32'(wr_pulses - w0), 32'd1);
    check({tag, "_no_err"}, 32'(err_pulses - e0), 32'd0);
    check({tag, "_miso_quiet"}, 32'(stray), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err()));
  endtask

  task automatic do_read(input logic [5:0] a, input string tag);
    int w0, e0;
    logic [19:0] rd, exp;
    bit stray;
    w0 = wr_pulses;
    e0 = err_pulses;
    if (ERR_EN && a == 6'd63) exp = 20'(model_err);
    else if (a < 6'd16)       exp = model[a[3:0]];
    else                      exp = '0;
    rd_q.push_back(exp);
    spi_frame(1'b0, a, 20'h0, 27, 0, 1'b0, rd, stray);
    exp = rd_q.pop_front();
    check({tag, "_data"}, 32'(rd), 32'(exp));
    check({tag, "_miso_quiet"}, 32'(stray), 32'd0);
    check({tag, "_no_write"}, 32'(wr_pulses - w0), 32'd0);
    check({tag, "_no_err"}, 32'(err_pulses - e0), 32'd0);
  endtask

  task automatic do_abort(input logic [5:0] a, input logic [19:0] d, input int nbits, input string tag);
    int w0, e0;
    logic [19:0] rd;
    bit stray;
    w0 = wr_pulses;
    e0 = err_pulses;
    spi_frame(1'b1, a, d, nbits, 0, 1'b0, rd, stray);
    if (model_err < 255) model_err++;
    check({tag, "_no_write"}, 32'(wr_pulses - w0), 32'd0);
    check({tag, "_err_pulse"}, 32'(err_pulses - e0), 32'd1);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err()));
  endtask

  initial begin
    int w0, e0;
    logic [19:0] rd;
    bit stray;
    logic [5:0] ra;

    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    model_err = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    do_write(6'd3, 20'hA5A5A, 27, 1'b0, "w3");
    do_read(6'd3, "r3");
    do_write(6'd20, 20'h12345, 27, 1'b0, "w20_unimpl");
    do_read(6'd20, "r20_unimpl");
    do_abort(6'd1, 20'hFFFFF, 15, "abort15");
    do_read(6'd1, "r1_kept");
    do_write(6'd2, 20'h00001, 35, 1'b0, "w2_35clk");
    do_read(6'd2, "r2");
    do_write(6'd9, 20'h5C3A7, 27, 1'b1, "w9_cs_sclk_same");
    do_read(6'd9, "r9");
    do_write(6'd15, 20'hFFFFF, 27, 1'b0, "w15_ones");
    for (int i = 0; i < 6; i++) begin
      ra = 6'($urandom_range(0, 15));
      do_write(ra, 20'($urandom), 27, 1'b0, "wrand");
    end
    for (int i = 0; i < 16; i++) do_read(6'(i), "rall");

    // reset mid-frame with CS_n still low: no write, no error, registers cleared
    w0 = wr_pulses;
    e0 = err_pulses;
    spi_frame(1'b1, 6'd4, 20'hABCDE, 27, 10, 1'b0, rd, stray);
    for (int i = 0; i < 16; i++) model[i] = '0;
    model_err = 0;
    check("midrst_no_write", 32'(wr_pulses - w0), 32'd0);
    check("midrst_no_err", 32'(err_pulses - e0), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    do_write(6'd5, 20'h13579, 27, 1'b0, "w5_after_rst");
    do_read(6'd5, "r5_after_rst");
    do_read(6'd4, "r4_after_rst");
    do_read(6'd3, "r3_cleared");

    // 300 aborted frames: counter saturates (or stays 0 when compiled out)
    e0 = err_pulses;
    for (int i = 0; i < 300; i++) begin
      spi_frame(1'b1, 6'd7, 20'h0, 1, 0, 1'b0, rd, stray);
      if (model_err < 255) model_err++;
    end
    check("abort300_pulses", 32'(err_pulses - e0), 32'd300);
    check("abort300_err_cnt", 32'(err_cnt), 32'(exp_err()));
    do_read(6'd63, "r63_errcnt");
    do_abort(6'd7, 20'h0, 3, "abort_sat");
    do_write(6'd63, 20'h00000, 27, 1'b0, "w63_clear");
    do_read(6'd63, "r63_cleared");
    do_read(6'd7, "r7_untouched");

    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
